// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared types and constants for the interrupt dispatcher:
//               dispatch FSM state encoding, vector address constants, source
//               count and source bit positions, and a vector address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    // Number of maskable interrupt sources and their bit positions in IF/IE.
    localparam int NUM_SRC    = 5;
    localparam int SRC_VBLANK = 0;
    localparam int SRC_STAT   = 1;
    localparam int SRC_TIMER  = 2;
    localparam int SRC_SERIAL = 3;
    localparam int SRC_JOYPAD = 4;

    // Handler address low bytes.
    localparam logic [7:0] VEC_BASE = 8'h40;
    localparam logic [7:0] VEC_STEP = 8'd8;
    localparam logic [7:0] VEC_NMI  = 8'h68;

    // Dispatch sequence states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        VEC   = 2'd2
    } irq_state_e;

    // Handler address for a maskable source index.
    function automatic logic [7:0] vec_addr(input logic [2:0] idx);
        return VEC_BASE + (VEC_STEP * {5'd0, idx});
    endfunction

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_prio.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio
// Description : Fixed-priority encoder. Bit 0 is the highest priority; idx is
//               the position of the lowest set bit of pending, any is the OR.
// Revision    : 1.0 - initial release
// Ports       : pending [NUM_SRC] in  - pending sources (IF & IE)
//               idx     [3]       out - index of the winning source
//               any     [1]       out - at least one source pending
// ============================================================================
module irq_prio
    import irq_pkg::*;
(
    input  logic [NUM_SRC-1:0] pending,
    output logic [2:0]         idx,
    output logic               any
);

    always_comb begin
        idx = 3'd0;
        any = |pending;
        // Scan from the lowest priority down so the lowest set bit wins last.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule : irq_prio
`default_nettype wire

// File: rtl/irq_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : irq_dispatch
// Description : Interrupt controller: edge-detects five source lines into IF,
//               masks with IE, manages the master enable (IME) with delayed
//               EI, and runs a three-state dispatch handshake that delivers a
//               handler vector two cycles after INT_ACK.
// Revision    : 1.0 - initial release
// Options     : IRQ_NMI_EN - adds the NMI input and a non-maskable flag with
//               top priority and vector 0x68.
// Ports       : CLK       in  1 - clock, rising edge
//               nRESET    in  1 - asynchronous active-low reset
//               IRQ_SRC   in  5 - source levels, rising edge is an event
//               REG_SEL   in  1 - 0 selects IF, 1 selects IE
//               REG_WR    in  1 - register write strobe
//               DIN       in  8 - write data
//               DOUT      out 8 - read data (combinational)
//               EI/DI     in  1 - enable/disable interrupt pulses
//               RETI      in  1 - return-from-interrupt pulse
//               INSTR_END in  1 - instruction boundary pulse
//               INT_REQ   out 1 - dispatch request (registered)
//               INT_ACK   in  1 - sequencer accepts the request
//               VECTOR    out 8 - handler address low byte
//               VEC_VALID out 1 - VECTOR valid strobe
//               NMI       in  1 - non-maskable source (IRQ_NMI_EN only)
//               WAKE      out 1 - wake request for HALT/STOP
// ============================================================================
module irq_dispatch
    import irq_pkg::*;
(
    input  logic                CLK,
    input  logic                nRESET,
    input  logic [NUM_SRC-1:0]  IRQ_SRC,
    input  logic                REG_SEL,
    input  logic                REG_WR,
    input  logic [7:0]          DIN,
    output logic [7:0]          DOUT,
    input  logic                EI,
    input  logic                DI,
    input  logic                RETI,
    input  logic                INSTR_END,
    output logic                INT_REQ,
    input  logic                INT_ACK,
    output logic [7:0]          VECTOR,
    output logic                VEC_VALID,
`ifdef IRQ_NMI_EN
    input  logic                NMI,
`endif
    output logic                WAKE
);

    irq_state_e         r_state, w_state_nxt;
    logic [NUM_SRC-1:0] r_src;
    logic [NUM_SRC-1:0] r_if, w_if_nxt;
    logic [NUM_SRC-1:0] r_ie, w_ie_nxt;
    logic [NUM_SRC-1:0] w_edge, w_pending, w_clr_mask;
    logic               r_armed;
    logic               r_ime, w_ime_nxt;
    logic               r_ime_pend, w_ime_pend_nxt;
    logic               r_int_req, w_int_req_nxt;
    logic [7:0]         r_vector, w_vector_nxt;
    logic               r_vec_valid, w_vec_valid_nxt;
    logic [2:0]         r_idx, w_idx_nxt;
    logic               r_hit, w_hit_nxt;
    logic [2:0]         w_prio_idx;
    logic               w_prio_any;
    logic               w_ack;
    logic               w_nmi_cur, w_nmi_nxt;
    logic               w_din_unused;

    assign w_din_unused = ^DIN[7:NUM_SRC];

    // r_armed stays low for the first cycle after reset so a source already
    // high at release is absorbed into the history register, not seen as an edge.
    assign w_edge    = r_armed ? (IRQ_SRC & ~r_src) : '0;
    assign w_pending = r_if & r_ie;
    assign w_ack     = INT_ACK && r_int_req && (r_state == IDLE);

    assign DOUT      = REG_SEL ? {3'b000, r_ie} : {3'b111, r_if};
    assign WAKE      = (|w_pending) | w_nmi_cur;
    assign INT_REQ   = r_int_req;
    assign VECTOR    = r_vector;
    assign VEC_VALID = r_vec_valid;

    irq_prio u_prio (
        .pending (w_pending),
        .idx     (w_prio_idx),
        .any     (w_prio_any)
    );

`ifdef IRQ_NMI_EN
    logic r_nmi_src, r_nmi_flag, r_nmi_sel, w_nmi_flag_nxt;

    always_comb begin
        w_nmi_flag_nxt = r_nmi_flag;
        if (r_state == VEC && r_nmi_sel) begin
            w_nmi_flag_nxt = 1'b0;
        end
        // A fresh edge in the clearing cycle must not be lost.
        if (r_armed && NMI && !r_nmi_src) begin
            w_nmi_flag_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_nmi_src  <= 1'b0;
            r_nmi_flag <= 1'b0;
            r_nmi_sel  <= 1'b0;
        end else begin
            r_nmi_src  <= NMI;
            r_nmi_flag <= w_nmi_flag_nxt;
            if (r_state == LATCH) begin
                r_nmi_sel <= r_nmi_flag;
            end
        end
    end

    assign w_nmi_cur = r_nmi_flag;
    assign w_nmi_nxt = w_nmi_flag_nxt;
`else
    assign w_nmi_cur = 1'b0;
    assign w_nmi_nxt = 1'b0;
`endif

    // IF/IE update. Priority, lowest to highest: register write, dispatch
    // clear of the serviced bit, new edge event.
    assign w_clr_mask = (r_state == VEC && r_hit) ? (NUM_SRC'(1) << r_idx) : '0;

    always_comb begin
        w_if_nxt = r_if;
        w_ie_nxt = r_ie;
        if (REG_WR && !REG_SEL) begin
            w_if_nxt = DIN[NUM_SRC-1:0];
        end
        if (REG_WR && REG_SEL) begin
            w_ie_nxt = DIN[NUM_SRC-1:0];
        end
        w_if_nxt = (w_if_nxt & ~w_clr_mask) | w_edge;
    end

    // Master enable. EI arms ime_pend; the boundary that promotes it must come
    // from a later cycle, so only the registered pend flag is tested. DI is
    // applied last so it overrides EI, RETI and the promotion.
    always_comb begin
        w_ime_nxt      = r_ime;
        w_ime_pend_nxt = r_ime_pend;
        if (r_ime_pend && INSTR_END) begin
            w_ime_nxt      = 1'b1;
            w_ime_pend_nxt = 1'b0;
        end
        if (EI) begin
            w_ime_pend_nxt = 1'b1;
        end
        if (RETI) begin
            w_ime_nxt = 1'b1;
        end
        if (w_ack) begin
            w_ime_nxt      = 1'b0;
            w_ime_pend_nxt = 1'b0;
        end
        if (DI) begin
            w_ime_nxt      = 1'b0;
            w_ime_pend_nxt = 1'b0;
        end
    end

    // Dispatch FSM next state and registered outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_vector_nxt    = r_vector;
        w_vec_valid_nxt = 1'b0;
        w_idx_nxt       = r_idx;
        w_hit_nxt       = r_hit;
        case (r_state)
            IDLE: begin
                if (w_ack) begin
                    w_state_nxt = LATCH;
                end
            end
            LATCH: begin
                // Pending is re-sampled here; an empty set yields vector 0x00.
                w_idx_nxt       = w_prio_idx;
                w_hit_nxt       = w_prio_any && !w_nmi_cur;
                w_vec_valid_nxt = 1'b1;
                if (w_nmi_cur) begin
                    w_vector_nxt = VEC_NMI;
                end else if (w_prio_any) begin
                    w_vector_nxt = vec_addr(w_prio_idx);
                end else begin
                    w_vector_nxt = 8'h00;
                end
                w_state_nxt = VEC;
            end
            VEC: begin
                w_hit_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The request is computed from next-state values so that the registered
    // output tracks the current IDLE/IME/pending condition without lag.
    assign w_int_req_nxt = (w_state_nxt == IDLE) &&
                           (w_nmi_nxt || (w_ime_nxt && |(w_if_nxt & w_ie_nxt)));

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= IDLE;
            r_src       <= '0;
            r_if        <= '0;
            r_ie        <= '0;
            r_armed     <= 1'b0;
            r_ime       <= 1'b0;
            r_ime_pend  <= 1'b0;
            r_int_req   <= 1'b0;
            r_vector    <= 8'h00;
            r_vec_valid <= 1'b0;
            r_idx       <= 3'd0;
            r_hit       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_src       <= IRQ_SRC;
            r_if        <= w_if_nxt;
            r_ie        <= w_ie_nxt;
            r_armed     <= 1'b1;
            r_ime       <= w_ime_nxt;
            r_ime_pend  <= w_ime_pend_nxt;
            r_int_req   <= w_int_req_nxt;
            r_vector    <= w_vector_nxt;
            r_vec_valid <= w_vec_valid_nxt;
            r_idx       <= w_idx_nxt;
            r_hit       <= w_hit_nxt;
        end
    end

endmodule : irq_dispatch
`default_nettype wire

// File: tb/tb_irq_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_dispatch
// Description : Directed self-checking bench for irq_dispatch. Inputs change
//               1 ns after the rising edge; outputs are sampled there too.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_dispatch;

    logic       CLK;
    logic       nRESET;
    logic [4:0] IRQ_SRC;
    logic       REG_SEL;
    logic       REG_WR;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       EI;
    logic       DI;
    logic       RETI;
    logic       INSTR_END;
    logic       INT_REQ;
    logic       INT_ACK;
    logic [7:0] VECTOR;
    logic       VEC_VALID;
    logic       WAKE;
`ifdef IRQ_NMI_EN
    logic       NMI;
`endif

    int checks = 0;
    int errors = 0;

    irq_dispatch dut (
        .CLK       (CLK),
        .nRESET    (nRESET),
        .IRQ_SRC   (IRQ_SRC),
        .REG_SEL   (REG_SEL),
        .REG_WR    (REG_WR),
        .DIN       (DIN),
        .DOUT      (DOUT),
        .EI        (EI),
        .DI        (DI),
        .RETI      (RETI),
        .INSTR_END (INSTR_END),
        .INT_REQ   (INT_REQ),
        .INT_ACK   (INT_ACK),
        .VECTOR    (VECTOR),
        .VEC_VALID (VEC_VALID),
`ifdef IRQ_NMI_EN
        .NMI       (NMI),
`endif
        .WAKE      (WAKE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic sel, input logic [7:0] data);
        REG_SEL = sel;
        DIN     = data;
        REG_WR  = 1'b1;
        tick();
        REG_WR  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic sel, input logic [7:0] exp);
        REG_SEL = sel;
        #1;
        chk(tag, DOUT, exp);
    endtask

    task automatic pulse_reti();
        RETI = 1'b1;
        tick();
        RETI = 1'b0;
    endtask

    task automatic ack();
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
    endtask

    initial begin
        nRESET = 1'b0; IRQ_SRC = '0; REG_SEL = 1'b0; REG_WR = 1'b0; DIN = '0;
        EI = 1'b0; DI = 1'b0; RETI = 1'b0; INSTR_END = 1'b0; INT_ACK = 1'b0;
`ifdef IRQ_NMI_EN
        NMI = 1'b0;
`endif
        #3;
        chk("rst_int_req", {7'd0, INT_REQ}, 8'h00);
        chk("rst_vec_valid", {7'd0, VEC_VALID}, 8'h00);
        chk("rst_vector", VECTOR, 8'h00);
        chk("rst_wake", {7'd0, WAKE}, 8'h00);
        rd("rst_if", 1'b0, 8'hE0);
        rd("rst_ie", 1'b1, 8'h00);
        tick(); tick();
        nRESET = 1'b1;
        tick();

        // Single TIMER dispatch.
        wr(1'b1, 8'h04);
        rd("ie_write", 1'b1, 8'h04);
        pulse_reti();
        IRQ_SRC = 5'b00100;
        tick();
        IRQ_SRC = 5'b00000;
        rd("timer_if", 1'b0, 8'hE4);
        chk("timer_wake", {7'd0, WAKE}, 8'h01);
        chk("timer_req", {7'd0, INT_REQ}, 8'h01);
        ack();
        chk("timer_latch_req", {7'd0, INT_REQ}, 8'h00);
        chk("timer_latch_valid", {7'd0, VEC_VALID}, 8'h00);
        tick();
        chk("timer_valid", {7'd0, VEC_VALID}, 8'h01);
        chk("timer_vector", VECTOR, 8'h50);
        tick();
        chk("timer_valid_drop", {7'd0, VEC_VALID}, 8'h00);
        rd("timer_if_clr", 1'b0, 8'hE0);
        IRQ_SRC = 5'b00100;
        tick();
        IRQ_SRC = 5'b00000;
        chk("timer_ime_off_wake", {7'd0, WAKE}, 8'h01);
        chk("timer_ime_off_req", {7'd0, INT_REQ}, 8'h00);
        wr(1'b0, 8'h00);

        // IME sequencing.
        wr(1'b1, 8'h1F);
        IRQ_SRC = 5'b00010;
        wr(1'b0, 8'h00);
        IRQ_SRC = 5'b00000;
        rd("edge_beats_ifwr", 1'b0, 8'hE2);
        wr(1'b0, 8'h01);
        chk("ime0_req", {7'd0, INT_REQ}, 8'h00);
        EI = 1'b1; INSTR_END = 1'b1;
        tick();
        EI = 1'b0; INSTR_END = 1'b0;
        chk("ei_same_end", {7'd0, INT_REQ}, 8'h00);
        tick();
        chk("ei_wait", {7'd0, INT_REQ}, 8'h00);
        INSTR_END = 1'b1;
        tick();
        INSTR_END = 1'b0;
        chk("ei_next_end", {7'd0, INT_REQ}, 8'h01);
        DI = 1'b1;
        tick();
        DI = 1'b0;
        chk("di_clears", {7'd0, INT_REQ}, 8'h00);
        EI = 1'b1; DI = 1'b1;
        tick();
        EI = 1'b0; DI = 1'b0;
        INSTR_END = 1'b1;
        tick();
        INSTR_END = 1'b0;
        chk("ei_di_same", {7'd0, INT_REQ}, 8'h00);
        RETI = 1'b1; DI = 1'b1;
        tick();
        RETI = 1'b0; DI = 1'b0;
        chk("reti_di_same", {7'd0, INT_REQ}, 8'h00);

        // IE cleared in the ack cycle: empty dispatch.
        pulse_reti();
        chk("empty_req", {7'd0, INT_REQ}, 8'h01);
        INT_ACK = 1'b1; REG_SEL = 1'b1; DIN = 8'h00; REG_WR = 1'b1;
        tick();
        INT_ACK = 1'b0; REG_WR = 1'b0;
        tick();
        chk("empty_valid", {7'd0, VEC_VALID}, 8'h01);
        chk("empty_vector", VECTOR, 8'h00);
        tick();
        rd("empty_if_kept", 1'b0, 8'hE1);
        rd("empty_ie", 1'b1, 8'h00);

        // SERIAL then JOYPAD, priority order.
        wr(1'b1, 8'h1F);
        wr(1'b0, 8'h18);
        chk("prio_ime0_req", {7'd0, INT_REQ}, 8'h00);
        pulse_reti();
        chk("prio_req", {7'd0, INT_REQ}, 8'h01);
        ack();
        tick();
        chk("serial_vector", VECTOR, 8'h58);
        tick();
        rd("serial_if_clr", 1'b0, 8'hF0);
        chk("serial_req_off", {7'd0, INT_REQ}, 8'h00);
        pulse_reti();
        ack();
        tick();
        chk("joypad_valid", {7'd0, VEC_VALID}, 8'h01);
        chk("joypad_vector", VECTOR, 8'h60);
        wr(1'b0, 8'h1F);
        rd("clr_beats_ifwr", 1'b0, 8'hEF);

        // Reset during LATCH with VBLANK held high.
        wr(1'b0, 8'h00);
        wr(1'b1, 8'h01);
        pulse_reti();
        IRQ_SRC = 5'b00001;
        tick();
        chk("vbl_req", {7'd0, INT_REQ}, 8'h01);
        ack();
        nRESET = 1'b0;
        #1;
        chk("mid_rst_req", {7'd0, INT_REQ}, 8'h00);
        chk("mid_rst_valid", {7'd0, VEC_VALID}, 8'h00);
        chk("mid_rst_vector", VECTOR, 8'h00);
        chk("mid_rst_wake", {7'd0, WAKE}, 8'h00);
        rd("mid_rst_if", 1'b0, 8'hE0);
        tick(); tick();
        nRESET = 1'b1;
        tick(); tick(); tick();
        rd("held_src_if", 1'b0, 8'hE0);
        chk("held_src_valid", {7'd0, VEC_VALID}, 8'h00);
        IRQ_SRC = 5'b00000;
        tick();

`ifdef IRQ_NMI_EN
        // NMI with IME=0 and IE=0.
        NMI = 1'b1;
        tick();
        NMI = 1'b0;
        chk("nmi_req", {7'd0, INT_REQ}, 8'h01);
        chk("nmi_wake", {7'd0, WAKE}, 8'h01);
        ack();
        tick();
        chk("nmi_valid", {7'd0, VEC_VALID}, 8'h01);
        chk("nmi_vector", VECTOR, 8'h68);
        tick();
        chk("nmi_req_off", {7'd0, INT_REQ}, 8'h00);
        chk("nmi_wake_off", {7'd0, WAKE}, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_irq_dispatch
`default_nettype wire
